// File: rtl/ps2_cmd_decoder_if.sv
// Byte stream from PS2_Controller and game-command outputs toward game_control_unit.
interface ps2_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rotate;
  logic       left;
  logic       right;
  logic       down;
  logic [3:0] key_held;
  logic [7:0] last_code;

  modport master (
    output rx_data, rx_valid,
    input  rotate, left, right, down, key_held, last_code
  );

  modport slave (
    input  rx_data, rx_valid,
    output rotate, left, right, down, key_held, last_code
  );
endinterface

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scancode parser (E0/F0 prefixes) producing one-hot held game commands
// with held-key tracking and single-slot auto-repeat for down/left/right.
module ps2_cmd_decoder #(
  parameter int unsigned HOLD_CYCLES    = 1_800_000,
  parameter int unsigned REPEAT_DELAY   = 50_000_000,
  parameter int unsigned REPEAT_PERIOD  = 10_000_000,
  parameter int unsigned PREFIX_TIMEOUT = 2_000_000,
  parameter logic [7:0]  KEY_ROT        = 8'h1D,
  parameter logic [7:0]  KEY_DOWN       = 8'h1B,
  parameter logic [7:0]  KEY_LEFT       = 8'h1C,
  parameter logic [7:0]  KEY_RIGHT      = 8'h23,
  parameter logic [7:0]  EXT_ROT        = 8'h75,
  parameter logic [7:0]  EXT_DOWN       = 8'h72,
  parameter logic [7:0]  EXT_LEFT       = 8'h6B,
  parameter logic [7:0]  EXT_RIGHT      = 8'h74
) (
  input  logic               clk,
  input  logic               rst,
  ps2_cmd_decoder_if.slave   bus
);

  localparam int unsigned MAX_A = (HOLD_CYCLES > REPEAT_DELAY) ? HOLD_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_B = (REPEAT_PERIOD > PREFIX_TIMEOUT) ? REPEAT_PERIOD : PREFIX_TIMEOUT;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LD  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LD = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] PFX_LAST  = CW'(PREFIX_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  // Key vectors are {rot, down, left, right}; rotate is excluded from repeat.
  localparam logic [3:0] REPEATABLE = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t        state, state_n;
  logic          ev_make, ev_break, ev_ext;
  logic [3:0]    key_oh;
  logic          press_new, release_key, slot_release;
  logic          rep_fire;
  logic [3:0]    fire_vec;

  logic [CW-1:0] pfx_cnt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] rep_cnt;
  logic [3:0]    cmd;
  logic [3:0]    held;
  logic [3:0]    slot;
  logic [7:0]    last_byte;

  function automatic logic [3:0] key_map(input logic ext, input logic [7:0] code);
    logic [3:0] k;
    k = '0;
    if (ext) begin
      if      (code == EXT_ROT)   k = 4'b1000;
      else if (code == EXT_DOWN)  k = 4'b0100;
      else if (code == EXT_LEFT)  k = 4'b0010;
      else if (code == EXT_RIGHT) k = 4'b0001;
    end else begin
      if      (code == KEY_ROT)   k = 4'b1000;
      else if (code == KEY_DOWN)  k = 4'b0100;
      else if (code == KEY_LEFT)  k = 4'b0010;
      else if (code == KEY_RIGHT) k = 4'b0001;
    end
    return k;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        S_IDLE: begin
          if      (bus.rx_data == 8'hF0) state_n = S_BRK;
          else if (bus.rx_data == 8'hE0) state_n = S_EXT;
          else                           ev_make = 1'b1;
        end
        S_EXT: begin
          if (bus.rx_data == 8'hF0) begin
            state_n = S_EXT_BRK;
          end else begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_BRK: begin
          ev_break = 1'b1;
          state_n  = S_IDLE;
        end
        S_EXT_BRK: begin
          ev_break = 1'b1;
          ev_ext   = 1'b1;
          state_n  = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && pfx_cnt >= PFX_LAST) begin
      state_n = S_IDLE;
    end
  end

  always_comb begin
    key_oh       = key_map(ev_ext, bus.rx_data);
    press_new    = ev_make && (key_oh != '0) && ((key_oh & held) == '0);
    release_key  = ev_break && (key_oh != '0);
    slot_release = release_key && ((key_oh & slot) != '0);
    // A release of the slot key in the same cycle suppresses its due repeat.
    rep_fire     = (slot != '0) && (rep_cnt <= CNT_ONE) && !slot_release;
    fire_vec     = '0;
    if (press_new)     fire_vec = key_oh;
    else if (rep_fire) fire_vec = slot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pfx_cnt <= '0;
    end else if (state == S_IDLE || bus.rx_valid) begin
      pfx_cnt <= '0;
    end else if (pfx_cnt != CNT_MAX) begin
      pfx_cnt <= pfx_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
    end else if (press_new) begin
      held <= held | key_oh;
    end else if (release_key) begin
      held <= held & ~key_oh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd      <= '0;
      hold_cnt <= '0;
    end else if (fire_vec != '0) begin
      cmd      <= fire_vec;
      hold_cnt <= HOLD_LD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CNT_ONE;
    end else begin
      cmd      <= '0;
    end
  end

  // Repeat counter counts down to the next due fire; it reloads on a due fire
  // even when that fire lost to a press, so the cadence is unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot    <= '0;
      rep_cnt <= '0;
    end else if (press_new && ((key_oh & REPEATABLE) != '0)) begin
      slot    <= key_oh;
      rep_cnt <= DELAY_LD;
    end else if (slot_release) begin
      slot    <= '0;
      rep_cnt <= '0;
    end else if (slot != '0) begin
      if (rep_cnt <= CNT_ONE) rep_cnt <= PERIOD_LD;
      else                    rep_cnt <= rep_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               last_byte <= '0;
    else if (bus.rx_valid) last_byte <= bus.rx_data;
  end

  assign bus.rotate    = cmd[3];
  assign bus.down      = cmd[2];
  assign bus.left      = cmd[1];
  assign bus.right     = cmd[0];
  assign bus.key_held  = held;
  assign bus.last_code = last_byte;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed-vector bench for ps2_cmd_decoder with small timing parameters.
module tb_ps2_cmd_decoder;

  logic clk;
  logic rst;

  ps2_cmd_decoder_if bus ();

  ps2_cmd_decoder #(
    .HOLD_CYCLES   (8),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5),
    .PREFIX_TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] cmd;
    logic [3:0] held;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_pass;
  int unsigned n_total;

  task automatic add(input logic v, input logic [7:0] d, input logic [3:0] cmd,
                     input logic [3:0] held, input logic [7:0] last);
    vec_t e;
    e.v = v; e.d = d; e.cmd = cmd; e.held = held; e.last = last;
    vecs.push_back(e);
  endtask

  task automatic add_idle(input int unsigned n, input logic [3:0] cmd,
                          input logic [3:0] held, input logic [7:0] last);
    for (int unsigned i = 0; i < n; i++) add(1'b0, 8'h00, cmd, held, last);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {cmd,held,last}=%h, expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] outs();
    return {bus.rotate, bus.down, bus.left, bus.right, bus.key_held, bus.last_code};
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  initial begin
    logic [3:0]  exp_cmd;
    n_pass  = 0;
    n_total = 0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 16'h0000);
    rst = 1'b0;

    // Plain press / release of A
    add(1, 8'h1C, 4'b0010, 4'b0010, 8'h1C);
    add_idle(7, 4'b0010, 4'b0010, 8'h1C);
    add_idle(1, 4'b0000, 4'b0010, 8'h1C);
    add(1, 8'hF0, 4'b0000, 4'b0010, 8'hF0);
    add(1, 8'h1C, 4'b0000, 4'b0000, 8'h1C);
    add_idle(1, 4'b0000, 4'b0000, 8'h1C);
    // Extended down arrow press / release
    add(1, 8'hE0, 4'b0000, 4'b0000, 8'hE0);
    add(1, 8'h72, 4'b0100, 4'b0100, 8'h72);
    add_idle(7, 4'b0100, 4'b0100, 8'h72);
    add_idle(1, 4'b0000, 4'b0100, 8'h72);
    add(1, 8'hE0, 4'b0000, 4'b0100, 8'hE0);
    add(1, 8'hF0, 4'b0000, 4'b0100, 8'hF0);
    add(1, 8'h72, 4'b0000, 4'b0000, 8'h72);
    // Unmapped make and break
    add(1, 8'h2A, 4'b0000, 4'b0000, 8'h2A);
    add(1, 8'hF0, 4'b0000, 4'b0000, 8'hF0);
    add(1, 8'h2A, 4'b0000, 4'b0000, 8'h2A);
    // Override: left then rotate three cycles later
    add(1, 8'h1C, 4'b0010, 4'b0010, 8'h1C);
    add_idle(2, 4'b0010, 4'b0010, 8'h1C);
    add(1, 8'h1D, 4'b1000, 4'b1010, 8'h1D);
    add_idle(7, 4'b1000, 4'b1010, 8'h1D);
    add_idle(1, 4'b0000, 4'b1010, 8'h1D);
    add(1, 8'hF0, 4'b0000, 4'b1010, 8'hF0);
    add(1, 8'h1C, 4'b0000, 4'b1000, 8'h1C);
    add(1, 8'hF0, 4'b0000, 4'b1000, 8'hF0);
    add(1, 8'h1D, 4'b0000, 4'b0000, 8'h1D);
    // Short gap after F0 keeps the break prefix
    add(1, 8'hF0, 4'b0000, 4'b0000, 8'hF0);
    add_idle(5, 4'b0000, 4'b0000, 8'hF0);
    add(1, 8'h1B, 4'b0000, 4'b0000, 8'h1B);
    // Prefix timeout: 1B after a long gap is a make
    add(1, 8'hF0, 4'b0000, 4'b0000, 8'hF0);
    add_idle(12, 4'b0000, 4'b0000, 8'hF0);
    add(1, 8'h1B, 4'b0100, 4'b0100, 8'h1B);
    add_idle(2, 4'b0100, 4'b0100, 8'h1B);
    add(1, 8'hF0, 4'b0100, 4'b0100, 8'hF0);
    add(1, 8'h1B, 4'b0100, 4'b0000, 8'h1B);
    add_idle(3, 4'b0100, 4'b0000, 8'h1B);
    add_idle(1, 4'b0000, 4'b0000, 8'h1B);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d", i), outs(), {vecs[i].cmd, vecs[i].held, vecs[i].last});
    end

    // Reset asserted mid-hold clears everything immediately
    step(1, 8'h1D);
    step(0, 8'h00);
    step(0, 8'h00);
    check("pre_reset_hold", outs(), {4'b1000, 4'b1000, 8'h1D});
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 8'h1D);
    for (int k = 1; k <= 9; k++) begin
      exp_cmd = (k <= 8) ? 4'b1000 : 4'b0000;
      check($sformatf("post_reset_rot_k%0d", k), outs(), {exp_cmd, 4'b1000, 8'h1D});
      if (k < 9) step(0, 8'h00);
    end
    step(1, 8'hF0);
    step(1, 8'h1D);
    check("post_reset_release", outs(), {4'b0000, 4'b0000, 8'h1D});

    // Reset between E0 and the next byte drops the prefix: 75 alone is unmapped
    step(1, 8'hE0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 8'h75);
    check("reset_drops_prefix", outs(), {4'b0000, 4'b0000, 8'h75});

    // Auto-repeat of D with typematic re-makes, then release
    step(1, 8'h23);
    for (int k = 1; k <= 40; k++) begin
      exp_cmd = ((k >= 1 && k <= 8) || (k >= 20 && k <= 37)) ? 4'b0001 : 4'b0000;
      if (bus.right !== exp_cmd[0] || {bus.rotate, bus.down, bus.left} !== 3'b000) begin
        n_total++;
        $display("FAIL repeat_k%0d: got cmd=%b, expected %b", k,
                 {bus.rotate, bus.down, bus.left, bus.right}, exp_cmd);
      end else begin
        n_total++;
        n_pass++;
      end
      if (k == 10 || k == 14)  step(1, 8'h23);
      else if (k == 31)        step(1, 8'hF0);
      else if (k == 32)        step(1, 8'h23);
      else                     step(0, 8'h00);
    end
    check("repeat_end", outs(), {4'b0000, 4'b0000, 8'h23});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
